// File: rtl/mem_bus_slave.sv
// -----------------------------------------------------------------------------
// mem_bus_slave
//
// Word-wide memory target for the CPU memory bus. Holds a synchronous word
// array and serves one read or write at a time. A request is accepted at a
// clock edge while the block is idle; after a programmable number of wait
// states a one-cycle mem_ready strobe reports completion, with mem_err
// flagging misaligned, out-of-range or conflicting (read+write) requests.
//
// Optional build macro: MEM_BYTE_STROBE_EN
//   defined   -> adds input mem_be[3:0]; writes update only the enabled
//                bytes, and a write with mem_be == 4'b0000 is an error.
//   undefined -> no mem_be port; every write is full-word.
//
// Parameters:
//   ADDR_WIDTH     log2 of the word count
//   BASE_ADDR      byte address of word 0
//   READ_LATENCY   cycles from accept edge to read ready  (1..15)
//   WRITE_LATENCY  cycles from accept edge to write ready (1..15)
//
// Ports:
//   mem_clk           in   clock, all state changes on the rising edge
//   mem_rst           in   synchronous active-high reset
//   mem_addr_bus      in   byte address (sampled at accept only)
//   mem_data_in_bus   in   write data (sampled at accept only)
//   mem_rd            in   read request
//   mem_wr            in   write request
//   mem_be            in   byte strobes (MEM_BYTE_STROBE_EN builds only)
//   mem_data_out_bus  out  read data, valid while mem_ready = 1; held between
//                          read responses, 0 after an errored read
//   mem_ready         out  one-cycle completion strobe
//   mem_err           out  error flag, qualified by mem_ready
//   mem_busy          out  high whenever a request is in flight
// -----------------------------------------------------------------------------
module mem_bus_slave #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic        mem_clk,
    input  logic        mem_rst,
    input  logic [31:0] mem_addr_bus,
    input  logic [31:0] mem_data_in_bus,
    input  logic        mem_rd,
    input  logic        mem_wr,
`ifdef MEM_BYTE_STROBE_EN
    input  logic [3:0]  mem_be,
`endif
    output logic [31:0] mem_data_out_bus,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_busy
);

    localparam int unsigned WORDS = 2 ** ADDR_WIDTH;

    // Wait counter is loaded with LATENCY-1 so that the response lands
    // exactly LATENCY edges after the accept edge.
    localparam logic [3:0] RD_CNT_INIT = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_CNT_INIT = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                state;
    logic [3:0]            wait_cnt;

    // Request captured at the accept edge; data-path registers, no reset.
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  err_q;

    logic [31:0]           mem_array [WORDS];

    logic [3:0]            acc_be;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_err;
    logic                  commit_wr;

    // Byte offset from the base, shifted down to a word index.
    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[ADDR_WIDTH+1:2];
    endfunction

    // Address is unusable if misaligned, below the base, or past the array.
    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        if (a[1:0] != 2'b00)
            return 1'b1;
        if (a < BASE_ADDR)
            return 1'b1;
        return (off >> (ADDR_WIDTH + 2)) != 32'd0;
    endfunction

    // Full error decision taken at the accept edge. Priority order does not
    // change the single error bit, but mirrors how faults are classified.
    function automatic logic request_bad(input logic        rd,
                                         input logic        wr,
                                         input logic [31:0] a,
                                         input logic [3:0]  be);
        if (rd && wr)
            return 1'b1;
        if (addr_bad(a))
            return 1'b1;
        // An all-zero strobe write would silently do nothing; report it.
        if (wr && (be == 4'b0000))
            return 1'b1;
        return 1'b0;
    endfunction

`ifdef MEM_BYTE_STROBE_EN
    assign acc_be = mem_be;
`else
    assign acc_be = 4'hF;
`endif

    assign acc_idx = word_index(mem_addr_bus);
    assign acc_err = request_bad(mem_rd, mem_wr, mem_addr_bus, acc_be);

    // Write commits on the edge that leaves WR_WAIT; reset on that same edge
    // aborts the write, so the array is untouched.
    assign commit_wr = !mem_rst && (state == WR_WAIT) && (wait_cnt == 4'd0) && !err_q;

    // Request FSM with registered outputs
    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state            <= IDLE;
            wait_cnt         <= 4'd0;
            mem_ready        <= 1'b0;
            mem_err          <= 1'b0;
            mem_busy         <= 1'b0;
            mem_data_out_bus <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    mem_err   <= 1'b0;
                    if (mem_rd || mem_wr) begin
                        idx_q    <= acc_idx;
                        wdata_q  <= mem_data_in_bus;
                        be_q     <= acc_be;
                        err_q    <= acc_err;
                        mem_busy <= 1'b1;
                        // rd+wr conflicts take the read path and read timing.
                        if (mem_rd) begin
                            state    <= RD_WAIT;
                            wait_cnt <= RD_CNT_INIT;
                        end else begin
                            state    <= WR_WAIT;
                            wait_cnt <= WR_CNT_INIT;
                        end
                    end
                end

                RD_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state            <= RESP;
                        mem_ready        <= 1'b1;
                        mem_err          <= err_q;
                        mem_data_out_bus <= err_q ? 32'd0 : mem_array[idx_q];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                WR_WAIT: begin
                    // Read data bus is deliberately left holding its value.
                    if (wait_cnt == 4'd0) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        mem_err   <= err_q;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                RESP: begin
                    // Request lines are not sampled here; the next IDLE cycle
                    // is the earliest point a new request can be accepted.
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    mem_err   <= 1'b0;
                    mem_busy  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    mem_err   <= 1'b0;
                    mem_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Word array with per-byte write enables; contents are never reset.
    always_ff @(posedge mem_clk) begin
        if (commit_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b])
                    mem_array[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_slave.sv
module tb_mem_bus_slave;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] din;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] dout;
    logic        ready;
    logic        err;
    logic        busy;

    always #5 clk = ~clk;

    mem_bus_slave #(
        .ADDR_WIDTH   (10),
        .BASE_ADDR    (32'h0000_0000),
        .READ_LATENCY (RD_LAT),
        .WRITE_LATENCY(WR_LAT)
    ) dut (
        .mem_clk         (clk),
        .mem_rst         (rst),
        .mem_addr_bus    (addr),
        .mem_data_in_bus (din),
        .mem_rd          (rd),
        .mem_wr          (wr),
`ifdef MEM_BYTE_STROBE_EN
        .mem_be          (be),
`endif
        .mem_data_out_bus(dout),
        .mem_ready       (ready),
        .mem_err         (err),
        .mem_busy        (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] last_rd  = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=1 required=0 at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_err"},  {31'd0, err},  {31'd0, mon_e.err});
                check({mon_e.name, "_data"}, dout,          mon_e.data);
                check({mon_e.name, "_cycle"}, 32'(cyc),     32'(mon_e.due));
                check({mon_e.name, "_busy"}, {31'd0, busy}, 32'd1);
            end
        end
    end

    // Issue one request from an idle negedge; returns at the next idle negedge.
    task automatic req(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] strobes,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input string name);
        exp_t e;
        int   n;
        e.name = name;
        e.err  = exp_err;
        e.due  = cyc + 1 + (r ? RD_LAT : WR_LAT);
        if (r) begin
            e.data  = exp_rdata;
            last_rd = exp_rdata;
        end else begin
            e.data = last_rd;
        end
        sb.push_back(e);
        rd   = r;
        wr   = w;
        addr = a;
        din  = d;
        be   = strobes;
        @(posedge clk);
        #1;
        rd   = 1'b0;
        wr   = 1'b0;
        addr = 32'hFFFF_FFFF;
        din  = 32'h0;
        n    = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 40);
        if (ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_ready required=ready", name);
            if (sb.size() != 0) void'(sb.pop_back());
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        rd   = 1'b0;
        wr   = 1'b0;
        addr = 32'h0;
        din  = 32'h0;
        be   = 4'hF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err",   {31'd0, err},   32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_data",  dout,           32'd0);

        // Write then read-back timing
        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, "wr_10");
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, "rd_10");

        // Misaligned read, then a clean read is unaffected
        req(1'b1, 1'b0, 32'h12, 32'h0, 4'hF, 1'b1, 32'h0, "rd_misalign");
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, "rd_10_again");

        // Conflicting read+write: error, read timing, array untouched
        req(1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b1, 32'h0, "rdwr_conflict");
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, "rd_10_post_conflict");

        // Misaligned write is rejected too
        req(1'b0, 1'b1, 32'h11, 32'h55555555, 4'hF, 1'b1, 32'h0, "wr_misalign");
        req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, "rd_10_post_miswr");

        // Out-of-range write must not alias onto low or high words
        req(1'b0, 1'b1, 32'h0,   32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, "wr_0");
        req(1'b0, 1'b1, 32'hFFC, 32'h5A5A5A5A, 4'hF, 1'b0, 32'h0, "wr_ffc");
        req(1'b0, 1'b1, 32'h1000, 32'h0BAD0BAD, 4'hF, 1'b1, 32'h0, "wr_oor");
        req(1'b1, 1'b0, 32'h0,   32'h0, 4'hF, 1'b0, 32'hA5A5A5A5, "rd_0");
        req(1'b1, 1'b0, 32'hFFC, 32'h0, 4'hF, 1'b0, 32'h5A5A5A5A, "rd_ffc");

        // Reset during write wait discards the write
        req(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, "wr_20_old");
        rd   = 1'b0;
        wr   = 1'b1;
        addr = 32'h20;
        din  = 32'hCAFEF00D;
        be   = 4'hF;
        @(posedge clk);
        #1;
        wr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_err",   {31'd0, err},   32'd0);
        check("midrst_busy",  {31'd0, busy},  32'd0);
        check("midrst_data",  dout,           32'd0);
        repeat (6) @(negedge clk);
        req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h0BADF00D, "rd_20_after_rst");

`ifdef MEM_BYTE_STROBE_EN
        req(1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF,    1'b0, 32'h0, "wr_40_full");
        req(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0010, 1'b0, 32'h0, "wr_40_byte1");
        req(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 1'b1, 32'h0, "wr_40_nobe");
        req(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, 1'b0, 32'h1122CC44, "rd_40");
`endif

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover_expectations actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_slave.md
Name: mem_bus_slave

Overview:
Word-wide memory responder for the CPU memory bus; it is the target end of the cpu_addr_bus / cpu_rd / cpu_wr / data-bus interface. It holds a synchronous word array and serves one read or write at a time through a request/ready handshake with programmable wait states. It reports misaligned, out-of-range and conflicting (read+write) requests on an error strobe. It replaces the zero-latency behavioural memory in the CPU testbench.

Parameters:
ADDR_WIDTH, 10, log2 of word count (1024 words)
BASE_ADDR, 32'h0000_0000, byte address of word 0
READ_LATENCY, 2, cycles from accept edge to read ready (legal 1..15)
WRITE_LATENCY, 1, cycles from accept edge to write ready (legal 1..15)

Ports:
mem_clk  in  1  clock, all state changes on rising edge
mem_rst  in  1  synchronous active-high reset
mem_addr_bus  in  32  byte address (driven from cpu_addr_bus)
mem_data_in_bus  in  32  write data (driven from cpu_data_out_bus)
mem_rd  in  1  read request
mem_wr  in  1  write request
mem_data_out_bus  out  32  read data (to cpu_data_in_bus); valid only while mem_ready=1
mem_ready  out  1  one-cycle completion strobe
mem_err  out  1  error flag, qualified by mem_ready
mem_busy  out  1  1 whenever state != IDLE

Behaviour:
- Clocking and reset: one clock, mem_clk; reset mem_rst is synchronous and active-high.
- Reset values:
  - outputs: mem_ready=0, mem_err=0, mem_busy=0, mem_data_out_bus=0.
  - internal: state=IDLE, wait counter=0.
  - array contents are not reset.
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESP.
- IDLE: at each edge, sample mem_rd/mem_wr. This is the accept edge.
  - Latch addr and data; load counter with LATENCY-1.
  - Error check at accept, in priority order:
    - rd&wr both high -> error.
    - addr[1:0]!=0 -> error.
    - addr<BASE_ADDR, or word index (addr-BASE_ADDR)>>2 >= 2**ADDR_WIDTH -> error.
  - Errored requests still take the normal latency of the requested type; for rd&wr, READ_LATENCY applies.
  - No request -> stay IDLE.
- RD_WAIT / WR_WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter is 0, enter RESP.
  - At that same edge:
    - read: array word registered into mem_data_out_bus, or 0 on error.
    - write: mem_data_in_bus latched at accept is committed, unless error.
- RESP: mem_ready=1 for exactly this one cycle, with mem_err valid. The next edge returns to IDLE without sampling the request.
- Latency: accept at edge k -> mem_ready high from edge k+LATENCY to edge k+LATENCY+1.
- Bus holding: mem_addr_bus, mem_data_in_bus, mem_rd and mem_wr are ignored outside IDLE; the requester need not hold them.
- Back-to-back requests: a request still asserted in the first IDLE cycle after RESP is accepted as a new request. The requester deasserts in the RESP cycle to avoid a repeat.
- mem_data_out_bus holds its value between read responses. A write response does not change it. An errored read drives 0.
- Reset mid-operation: a pending write is discarded with the array unchanged, and no mem_ready is issued.
- Error writes never modify the array.

Optional Feature:
MEM_BYTE_STROBE_EN
- Defined:
  - Adds input port mem_be[3:0].
  - Writes update only bytes whose strobe bit is set (bit0=[7:0] ... bit3=[31:24]).
  - mem_be is latched at accept.
  - mem_be=4'b0000 on a write is an error.
  - Reads ignore mem_be.
- Undefined: the port is absent and every write is full-word.

Test Plan:
- Write and read-back timing: write 32'hDEADBEEF @0x10, then read 0x10 (READ_LATENCY=2).
  - mem_ready high exactly 2 edges after the read accept edge, for 1 cycle.
  - data=32'hDEADBEEF; mem_err=0.
- Misaligned read: read @0x12 -> mem_ready with mem_err=1 and data=0; a following read of 0x10 still returns 32'hDEADBEEF.
- Conflicting request: mem_rd=mem_wr=1 @0x10 with data 32'h12345678 -> mem_err=1; read-back of 0x10 = 32'hDEADBEEF.
- Out-of-range write: write @0x1000 (ADDR_WIDTH=10, BASE 0) -> mem_err=1; no array word changes (spot-check 0x0 and 0xFFC).
- Reset during write wait: WRITE_LATENCY=3, write 32'hCAFEF00D @0x20, assert mem_rst one edge after accept.
  - No mem_ready pulse; all outputs 0 the cycle after reset.
  - Read 0x20 returns its old value.
- Byte strobes (MEM_BYTE_STROBE_EN): write 32'h11223344 @0x40 with be=4'hF, then write 32'hAABBCCDD with be=4'b0010 -> read 0x40 returns 32'h1122CC44.
